neuron_mac: RTL and testbench
=============================

Name: neuron_mac

Overview:
- Sequential multiply-accumulate neuron; sits directly downstream of the pixel-to-fixed-point converter.
- Consumes a stream of IWIDTH converted inputs, each Q8.24 signed (1.0 = 32'h01000000), paired with a Q8.24 weight.
- Adds the weighted sum to a bias and presents one Q8.24 pre-activation result to the sigmoid stage.

Parameters:
- DWIDTH, 32, data/weight/bias/result width (signed fixed-point).
- IWIDTH, 64, number of inputs accumulated per neuron evaluation.
- FRAC, 24, fractional bits of the fixed-point format.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins an evaluation and loads bias.
- bias  input  DWIDTH  signed Q8.24 bias; sampled when start is accepted.
- in_valid  input  1  x_in/w_in valid.
- in_ready  output  1  block accepts a beat.
- x_in  input  DWIDTH  converted input value (Q8.24).
- w_in  input  DWIDTH  weight for x_in (Q8.24).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DWIDTH  signed Q8.24 weighted sum plus bias.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, count=0, in_ready=0, out_valid=0, out_data=0, busy=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - start=1 loads acc<=bias and count<=0, then moves to ACCUM.
  - in_valid is ignored.
- ACCUM:
  - in_ready=1.
  - A beat is accepted when in_valid&in_ready: acc<=acc+prod and count<=count+1.
  - The beat with count==IWIDTH-1 moves the block to DONE.
  - No beat means hold.
- DONE:
  - out_valid=1, out_data=acc (registered; stable while out_valid&!out_ready), in_ready=0.
  - out_valid&out_ready returns the block to IDLE next cycle; out_valid drops that cycle.
- start while not in IDLE is ignored; bias is not resampled.
- start and out_ready accepted in the same DONE cycle: start is ignored. A new evaluation needs start in IDLE.
- Arithmetic:
  - prod = signed(x_in)*signed(w_in) as a 2*DWIDTH product, arithmetic-shifted right by FRAC, truncated to DWIDTH bits (bits [DWIDTH+FRAC-1:FRAC]).
  - Truncation is toward negative infinity.
  - The accumulate is DWIDTH-bit signed; overflow behaviour is set by the optional feature.
- Latency:
  - out_valid rises one cycle after the last beat is accepted.
  - Minimum evaluation is 1 (start) + IWIDTH + 1 cycles.
- count width: clog2(IWIDTH); must not wrap before DONE.
- Reset mid-operation aborts immediately to the reset values; partial sums are discarded.

Optional Feature:
- Macro: NEURON_MAC_SAT_EN.
- Defined: each accumulate saturates to 32'h7FFFFFFF on positive overflow and to 32'h80000000 on negative overflow. Overflow is judged on the DWIDTH+1-bit sum. Product truncation is unaffected.
- Undefined: two's-complement wrap-around on the DWIDTH-bit sum.

Decomposition:
- Shared package/include holds:
  - Q-format constants: FRAC=24, ONE=32'h01000000, SAT_MAX=32'h7FFFFFFF, SAT_MIN=32'h80000000.
  - State encodings for IDLE/ACCUM/DONE.
  - A clog2 helper.
- One natural sub-module, fxp_mul: combinational signed Q8.24 multiply with shift and truncate, reusable by later layers.
- FSM, counter and accumulator stay in neuron_mac.

Test Plan:
- IWIDTH=4, bias=0, x={1.0,1.0,0,1.0} (32'h01000000/0), w={0.5,0.25,2.0,-1.0} -> out_data=32'hFFC00000 (-0.25), out_valid one cycle after the 4th beat.
- bias=32'h00800000 (0.5), all x=0 -> out_data=32'h00800000; in_valid gaps inserted mid-stream -> same result, count holds during gaps.
- Overflow, acc=32'h7F000000 plus prod=32'h02000000 -> with NEURON_MAC_SAT_EN out_data=32'h7FFFFFFF; without it, out_data=32'h81000000.
- out_ready held low 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, a start pulse is ignored; release -> IDLE next cycle.
- rst asserted after 2 of 4 beats -> all outputs 0 immediately; a new start with bias=0 and four beats of x=1.0, w=1.0 -> out_data=32'h04000000.
- in_valid pulsed while IDLE (no start) -> no accept, in_ready=0, acc unchanged.

Source files
------------

// File: rtl/neuron_mac_pkg.sv
// Shared Q8.24 constants, FSM state encoding and a clog2 helper for the neuron MAC.
package neuron_mac_pkg;

  localparam int          Q_FRAC    = 24;
  localparam logic [31:0] Q_ONE     = 32'h0100_0000;
  localparam logic [31:0] Q_SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Never returns less than 1 so a single-input neuron still gets a legal counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Handshake bundle between the neuron MAC and its driver (converter / sigmoid side).
interface neuron_mac_if #(
  parameter int DWIDTH = 32
);
  logic              start;
  logic [DWIDTH-1:0] bias;
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] x_in;
  logic [DWIDTH-1:0] w_in;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic              busy;

  modport master (
    output start, bias, in_valid, x_in, w_in, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, bias, in_valid, x_in, w_in, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/neuron_mac_fxp_mul.sv
// Combinational signed fixed-point multiply: full product shifted right by FRAC,
// truncated toward negative infinity to DWIDTH bits.
module neuron_mac_fxp_mul #(
  parameter int DWIDTH = 32,
  parameter int FRAC   = 24
) (
  input  logic signed [DWIDTH-1:0] i_a,
  input  logic signed [DWIDTH-1:0] i_b,
  output logic signed [DWIDTH-1:0] o_p
);

  logic signed [2*DWIDTH-1:0] w_full;

  assign w_full = (2*DWIDTH)'(i_a) * (2*DWIDTH)'(i_b);
  assign o_p    = DWIDTH'(w_full >>> FRAC);

endmodule

// File: rtl/neuron_mac.sv
// Sequential MAC neuron: bias + sum of IWIDTH Q8.24 products, one result per evaluation.
// Define NEURON_MAC_SAT_EN to saturate the accumulator instead of wrapping.
module neuron_mac
  import neuron_mac_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int IWIDTH = 64,
  parameter int FRAC   = Q_FRAC
) (
  input  logic         clk,
  input  logic         rst,
  neuron_mac_if.slave  bus
);

  localparam int             CW   = clog2(IWIDTH);
  localparam logic [CW-1:0]  LAST = CW'(IWIDTH - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CW-1:0]            r_count;
  logic signed [DWIDTH-1:0] r_acc;
  logic signed [DWIDTH-1:0] w_prod;
  logic signed [DWIDTH-1:0] w_acc_nxt;
  logic                     w_load;
  logic                     w_beat;
  logic                     w_in_ready;
  logic                     w_out_valid;
  logic                     w_busy;

  neuron_mac_fxp_mul #(
    .DWIDTH (DWIDTH),
    .FRAC   (FRAC)
  ) u_fxp_mul (
    .i_a (bus.x_in),
    .i_b (bus.w_in),
    .o_p (w_prod)
  );

`ifdef NEURON_MAC_SAT_EN
  logic signed [DWIDTH:0] w_sum;

  assign w_sum = {r_acc[DWIDTH-1], r_acc} + {w_prod[DWIDTH-1], w_prod};

  // Top two bits disagree only when the true sum left the DWIDTH-bit range.
  always_comb begin
    w_acc_nxt = w_sum[DWIDTH-1:0];
    if (w_sum[DWIDTH] != w_sum[DWIDTH-1]) begin
      w_acc_nxt = w_sum[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}}
                                : {1'b0, {(DWIDTH-1){1'b1}}};
    end
  end
`else
  assign w_acc_nxt = r_acc + w_prod;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_beat      = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (bus.in_valid) begin
          w_beat = 1'b1;
          if (r_count == LAST) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // A start arriving here is dropped; only IDLE launches an evaluation.
        w_out_valid = 1'b1;
        w_busy      = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_load) begin
      r_acc   <= bus.bias;
      r_count <= '0;
    end else if (w_beat) begin
      r_acc   <= w_acc_nxt;
      r_count <= r_count + CW'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_acc;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with IWIDTH=4; expected values hand-computed in Q8.24.
module tb_neuron_mac;

  localparam logic [31:0] ONE = 32'h0100_0000;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [31:0] exp_ovf;

  always #5 clk = ~clk;

  neuron_mac_if #(.DWIDTH(32)) bus ();

  neuron_mac #(
    .DWIDTH (32),
    .IWIDTH (4),
    .FRAC   (24)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Bias is scrambled after the start cycle so any resampling shows up in the result.
  task automatic do_start(input logic [31:0] b);
    bus.start = 1'b1;
    bus.bias  = b;
    cyc();
    bus.start = 1'b0;
    bus.bias  = 32'hDEAD_BEEF;
  endtask

  task automatic beat(input logic [31:0] x, input logic [31:0] w);
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    bus.w_in     = w;
    cyc();
    bus.in_valid = 1'b0;
    bus.x_in     = 32'h5A5A_5A5A;
    bus.w_in     = 32'hA5A5_A5A5;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
  endtask

  initial begin
`ifdef NEURON_MAC_SAT_EN
    exp_ovf = 32'h7FFF_FFFF;
`else
    exp_ovf = 32'h8100_0000;
`endif
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.bias      = '0;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.w_in      = '0;
    bus.out_ready = 1'b0;
    cyc();
    cyc();
    check("rst_in_ready",  32'(bus.in_ready),  0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data",  bus.out_data,       0);
    check("rst_busy",      32'(bus.busy),      0);
    rst = 1'b0;
    cyc();

    // 1*0.5 + 1*0.25 + 0*2 + 1*(-1) = -0.25
    do_start(32'h0);
    check("t1_in_ready", 32'(bus.in_ready), 1);
    check("t1_busy",     32'(bus.busy),     1);
    beat(ONE, 32'h0080_0000);
    beat(ONE, 32'h0040_0000);
    beat(32'h0, 32'h0200_0000);
    check("t1_valid_early", 32'(bus.out_valid), 0);
    beat(ONE, 32'hFF00_0000);
    check("t1_out_valid", 32'(bus.out_valid), 1);
    check("t1_out_data",  bus.out_data,       32'hFFC0_0000);
    check("t1_in_ready_done", 32'(bus.in_ready), 0);
    release_result();
    check("t1_valid_drop", 32'(bus.out_valid), 0);
    check("t1_idle_busy",  32'(bus.busy),      0);

    // Zero inputs with gaps: result is the bias alone.
    do_start(32'h0080_0000);
    beat(32'h0, ONE);
    cyc();
    beat(32'h0, ONE);
    cyc();
    cyc();
    beat(32'h0, ONE);
    check("t2_gap_in_ready", 32'(bus.in_ready),  1);
    cyc();
    check("t2_gap_hold",     32'(bus.out_valid), 0);
    beat(32'h0, ONE);
    check("t2_out_valid", 32'(bus.out_valid), 1);
    check("t2_out_data",  bus.out_data,       32'h0080_0000);
    release_result();

    // -1 LSB * 0.5 floors to -1 LSB.
    do_start(32'h0);
    beat(32'hFFFF_FFFF, 32'h0080_0000);
    beat(32'h0, 32'h0);
    beat(32'h0, 32'h0);
    beat(32'h0, 32'h0);
    check("t3_trunc_floor", bus.out_data, 32'hFFFF_FFFF);
    release_result();

    // 0x7F000000 + 2.0 overflows; then output held under backpressure.
    do_start(32'h7F00_0000);
    beat(32'h0200_0000, ONE);
    beat(32'h0, 32'h0);
    beat(32'h0, 32'h0);
    beat(32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid",    32'(bus.out_valid), 1);
      check("t4_hold_data",     bus.out_data,       exp_ovf);
      check("t4_hold_in_ready", 32'(bus.in_ready),  0);
      bus.start = (i == 2);
      bus.bias  = 32'h0;
      cyc();
      bus.start = 1'b0;
    end
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check("t4_rel_valid", 32'(bus.out_valid), 0);
    check("t4_rel_busy",  32'(bus.busy),      0);
    cyc();
    check("t4_start_ignored", 32'(bus.busy), 0);

    // Reset mid-evaluation, then a clean 4 x (1.0*1.0) run.
    do_start(32'h1234_5678);
    beat(ONE, ONE);
    beat(ONE, ONE);
    check("t5_busy_mid", 32'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_in_ready",  32'(bus.in_ready),  0);
    check("t5_rst_out_valid", 32'(bus.out_valid), 0);
    check("t5_rst_out_data",  bus.out_data,       0);
    check("t5_rst_busy",      32'(bus.busy),      0);
    cyc();
    rst = 1'b0;
    cyc();
    do_start(32'h0);
    for (int i = 0; i < 4; i++) beat(ONE, ONE);
    check("t5_out_valid", 32'(bus.out_valid), 1);
    check("t5_out_data",  bus.out_data,       32'h0400_0000);
    release_result();

    // in_valid while IDLE must not be accepted.
    bus.in_valid = 1'b1;
    bus.x_in     = ONE;
    bus.w_in     = ONE;
    check("t6_in_ready", 32'(bus.in_ready), 0);
    cyc();
    cyc();
    bus.in_valid = 1'b0;
    check("t6_acc_hold",  bus.out_data,       32'h0400_0000);
    check("t6_busy",      32'(bus.busy),      0);
    check("t6_out_valid", 32'(bus.out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
